// File: rtl/maxpool_seq_ctrl_if.sv
// Memory and pooling-datapath port bundle for maxpool_seq_ctrl.
// A *_req is held with stable address/data until its *_gnt is seen high on a rising edge
// (transfer happens on that edge); rd_rvalid qualifies rd_rdata for exactly one cycle.
interface maxpool_seq_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_rvalid;
    logic [191:0]      rd_rdata;
    logic [383:0]      pool_rdata;
    logic [95:0]       pool_wdata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [95:0]       wr_data;
    logic              wr_gnt;

    modport master (
        output rd_req, rd_addr, pool_rdata, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_rvalid, rd_rdata, pool_wdata, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, pool_rdata, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_rvalid, rd_rdata, pool_wdata, wr_gnt
    );
endinterface

// File: rtl/maxpool_seq_ctrl.sv
// Sequencer for a 2x2 stride-2 int16 max-pool: walks row pairs and chunks, fetching
// top/bottom 192-bit chunks for the datapath and writing back its 96-bit result.
module maxpool_seq_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DIM_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] src_stride,
    input  logic [ADDR_W-1:0] dst_stride,
    input  logic [DIM_W-1:0]  out_rows,
    input  logic [DIM_W-1:0]  chunks,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg,
    maxpool_seq_ctrl_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_TOP, S_WAIT_TOP, S_RD_BOT, S_WAIT_BOT, S_WR, S_FIN
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] src_stride_q, dst_stride_q;
    logic [DIM_W-1:0]  rows_q, chunks_q, r, c;
    logic [ADDR_W-1:0] src_row, src_cur, dst_row, dst_cur;
    logic [383:0]      pool_q;
    logic              last_chunk, last_row;

    assign last_chunk    = (c == chunks_q - DIM_W'(1));
    assign last_row      = (r == rows_q - DIM_W'(1));
    assign state_dbg     = state;
    assign mem.pool_rdata = pool_q;
    // pool_wdata depends only on the registered pool_q, so it is stable across WR.
    assign mem.wr_data   = mem.pool_wdata;

    always_comb begin
        state_n     = state;
        mem.rd_req  = 1'b0;
        mem.rd_addr = '0;
        mem.wr_req  = 1'b0;
        mem.wr_addr = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (out_rows == '0 || chunks == '0) ? S_FIN : S_RD_TOP;
                end
            end
            S_RD_TOP: begin
                mem.rd_req  = 1'b1;
                mem.rd_addr = src_cur;
                if (mem.rd_gnt) state_n = S_WAIT_TOP;
            end
            S_WAIT_TOP: begin
                if (mem.rd_rvalid) state_n = S_RD_BOT;
            end
            S_RD_BOT: begin
                mem.rd_req  = 1'b1;
                mem.rd_addr = src_cur + src_stride_q;
                if (mem.rd_gnt) state_n = S_WAIT_BOT;
            end
            S_WAIT_BOT: begin
                if (mem.rd_rvalid) state_n = S_WR;
            end
            S_WR: begin
                mem.wr_req  = 1'b1;
                mem.wr_addr = dst_cur;
                if (mem.wr_gnt) state_n = (last_chunk && last_row) ? S_FIN : S_RD_TOP;
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            rows_q       <= '0;
            chunks_q     <= '0;
            r            <= '0;
            c            <= '0;
            src_row      <= '0;
            src_cur      <= '0;
            dst_row      <= '0;
            dst_cur      <= '0;
            pool_q       <= '0;
        end else begin
            state <= state_n;
            done  <= (state == S_FIN);
            if (state == S_IDLE && start) begin
                busy         <= 1'b1;
                src_stride_q <= src_stride;
                dst_stride_q <= dst_stride;
                rows_q       <= out_rows;
                chunks_q     <= chunks;
                r            <= '0;
                c            <= '0;
                src_row      <= src_base;
                src_cur      <= src_base;
                dst_row      <= dst_base;
                dst_cur      <= dst_base;
            end
            if (state == S_FIN) busy <= 1'b0;
            if (state == S_WAIT_TOP && mem.rd_rvalid) pool_q[191:0]   <= mem.rd_rdata;
            if (state == S_WAIT_BOT && mem.rd_rvalid) pool_q[383:192] <= mem.rd_rdata;
            // Addresses advance incrementally: 24 bytes per input chunk, 12 per output chunk,
            // and two source rows per output row.
            if (state == S_WR && mem.wr_gnt) begin
                if (!last_chunk) begin
                    c       <= c + DIM_W'(1);
                    src_cur <= src_cur + ADDR_W'(24);
                    dst_cur <= dst_cur + ADDR_W'(12);
                end else if (!last_row) begin
                    c       <= '0;
                    r       <= r + DIM_W'(1);
                    src_row <= src_row + (src_stride_q << 1);
                    src_cur <= src_row + (src_stride_q << 1);
                    dst_row <= dst_row + dst_stride_q;
                    dst_cur <= dst_row + dst_stride_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Bench for maxpool_seq_ctrl: memory responder with programmable stalls, a stand-in
// pooling datapath, and a scoreboard built from the row/chunk walk arithmetic.
module tb_maxpool_seq_ctrl;
    localparam int AW = 64;
    localparam int W  = AW + 96;

    logic          clock, reset, start;
    logic [AW-1:0] src_base, dst_base, src_stride, dst_stride;
    logic [15:0]   out_rows, chunks;
    logic          busy, done;
    logic [2:0]    state_dbg;

    maxpool_seq_ctrl_if #(.ADDR_W(AW)) mem_if ();

    maxpool_seq_ctrl #(.ADDR_W(AW), .DIM_W(16)) dut (
        .clock(clock), .reset(reset), .start(start),
        .src_base(src_base), .dst_base(dst_base),
        .src_stride(src_stride), .dst_stride(dst_stride),
        .out_rows(out_rows), .chunks(chunks),
        .busy(busy), .done(done), .state_dbg(state_dbg),
        .mem(mem_if)
    );

    typedef struct {
        logic [63:0] src, dst, ss, ds;
        logic [15:0] rows, chunks;
        int          gd, rv, wd, mid;
        int          exp_lat, exp_wr;
    } vec_t;

    int             checks, errors;
    logic [W-1:0]   exp_q[$], obs_wr_q[$];
    logic [63:0]    exp_rd_q[$], obs_rd_q[$];
    logic [191:0]   mem_a [logic [63:0]];
    int             gnt_dly, rv_dly, wr_dly;
    int             n_done, n_rd_gnt;
    vec_t           tbl[5];

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference helpers ----------------
    function automatic logic [95:0] pool_ref(input logic [191:0] t, input logic [191:0] b);
        logic [95:0]       o;
        logic signed [15:0] m, e;
        o = '0;
        for (int j = 0; j < 6; j++) begin
            m = t[32*j +: 16];
            e = t[32*j+16 +: 16]; if (e > m) m = e;
            e = b[32*j +: 16];    if (e > m) m = e;
            e = b[32*j+16 +: 16]; if (e > m) m = e;
            o[16*j +: 16] = m;
        end
        return o;
    endfunction

    function automatic logic [191:0] get_mem(input logic [63:0] a);
        logic [191:0] v;
        if (!mem_a.exists(a)) begin
            for (int i = 0; i < 6; i++) v[32*i +: 32] = $urandom;
            mem_a[a] = v;
        end
        return mem_a[a];
    endfunction

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // stand-in pooling datapath
    assign mem_if.pool_wdata = pool_ref(mem_if.pool_rdata[191:0], mem_if.pool_rdata[383:192]);

    // ---------------- memory responder ----------------
    initial begin : responder
        int           rd_stall, wr_stall, rv_cnt;
        bit           rv_pend;
        logic [63:0]  rd_a0, wr_a0;
        logic [95:0]  wr_d0;
        logic [191:0] rv_data;
        rd_stall = 0; wr_stall = 0; rv_cnt = 0; rv_pend = 0;
        mem_if.rd_gnt = 1'b0; mem_if.rd_rvalid = 1'b0; mem_if.wr_gnt = 1'b0;
        mem_if.rd_rdata = '0;
        forever begin
            @(negedge clock);
            mem_if.rd_gnt    = 1'b0;
            mem_if.rd_rvalid = 1'b0;
            mem_if.wr_gnt    = 1'b0;
            mem_if.rd_rdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    mem_if.rd_rvalid = 1'b1;
                    mem_if.rd_rdata  = rv_data;
                    rv_pend = 0;
                end else rv_cnt--;
            end
            if (mem_if.rd_req && !reset) begin
                if (rd_stall == 0) rd_a0 = mem_if.rd_addr;
                else chk("rd_addr_stable", mem_if.rd_addr, rd_a0);
                if (rd_stall >= gnt_dly) begin
                    mem_if.rd_gnt = 1'b1;
                    rd_stall = 0;
                    obs_rd_q.push_back(mem_if.rd_addr);
                    rv_pend = 1; rv_cnt = rv_dly; rv_data = get_mem(mem_if.rd_addr);
                    n_rd_gnt++;
                end else rd_stall++;
            end else rd_stall = 0;
            if (mem_if.wr_req && !reset) begin
                if (wr_stall == 0) begin
                    wr_a0 = mem_if.wr_addr; wr_d0 = mem_if.wr_data;
                end else begin
                    chk("wr_addr_stable", mem_if.wr_addr, wr_a0);
                    chk("wr_data_stable", mem_if.wr_data, wr_d0);
                end
                if (wr_stall >= wr_dly) begin
                    mem_if.wr_gnt = 1'b1;
                    wr_stall = 0;
                    obs_wr_q.push_back({mem_if.wr_addr, mem_if.wr_data});
                end else wr_stall++;
            end else wr_stall = 0;
        end
    end

    initial begin : done_counter
        forever begin
            @(negedge clock);
            if (done) n_done++;
        end
    end

    // ---------------- driver / scoreboard ----------------
    task automatic run_job(input vec_t v);
        logic [63:0] ta;
        int          lat, n0, budget;
        bit          got;
        exp_q.delete(); exp_rd_q.delete(); obs_rd_q.delete(); obs_wr_q.delete();
        gnt_dly = v.gd; rv_dly = v.rv; wr_dly = v.wd;
        for (int r = 0; r < int'(v.rows); r++) begin
            for (int c = 0; c < int'(v.chunks); c++) begin
                ta = v.src + 64'(2*r) * v.ss + 64'(24*c);
                exp_rd_q.push_back(ta);
                exp_rd_q.push_back(ta + v.ss);
                exp_q.push_back({v.dst + 64'(r) * v.ds + 64'(12*c),
                                 pool_ref(get_mem(ta), get_mem(ta + v.ss))});
            end
        end
        budget = 20 + 40 * int'(v.rows) * int'(v.chunks);
        @(negedge clock);
        src_base = v.src; dst_base = v.dst; src_stride = v.ss; dst_stride = v.ds;
        out_rows = v.rows; chunks = v.chunks; start = 1'b1;
        n0 = n_done; got = 0; lat = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clock);
            if (n == 1) chk("busy_rise", busy, 1);
            if (done) begin got = 1; lat = n; break; end
            start = (n == v.mid);
            if (n == v.mid) begin
                src_base = {$urandom, $urandom}; out_rows = 16'd7; chunks = 16'd7;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        if (v.exp_lat > 0) chk("done_latency", lat, v.exp_lat);
        repeat (3) @(negedge clock);
        chk("done_once", n_done - n0, 1);
        chk("busy_fall", busy, 0);
        chk("wr_count", obs_wr_q.size(), v.exp_wr);
        chk("rd_count", obs_rd_q.size(), exp_rd_q.size());
        for (int i = 0; i < exp_rd_q.size() && i < obs_rd_q.size(); i++)
            chk("rd_addr_seq", obs_rd_q[i], exp_rd_q[i]);
        for (int i = 0; i < exp_q.size() && i < obs_wr_q.size(); i++)
            chk("wr_addr_data", obs_wr_q[i], exp_q[i]);
    endtask

    initial begin : main
        logic [191:0] t, b;
        vec_t         v;
        int           n0;
        checks = 0; errors = 0; n_done = 0; n_rd_gnt = 0;
        gnt_dly = 0; rv_dly = 0; wr_dly = 0;
        start = 1'b0; reset = 1'b1;
        src_base = '0; dst_base = '0; src_stride = '0; dst_stride = '0;
        out_rows = '0; chunks = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_req", mem_if.rd_req, 0);
        chk("rst_wr_req", mem_if.wr_req, 0);
        chk("rst_rd_addr", mem_if.rd_addr, 0);
        chk("rst_wr_addr", mem_if.wr_addr, 0);
        chk("rst_pool_rdata", mem_if.pool_rdata, 0);

        // known rows: top 0..11, bottom 100..111
        for (int i = 0; i < 12; i++) begin
            t[16*i +: 16] = 16'(i);
            b[16*i +: 16] = 16'(100 + i);
        end
        mem_a[64'h1000] = t;
        mem_a[64'h1040] = b;

        //            src          dst          ss       ds      rows chk gd rv wd mid lat wr
        tbl[0] = '{64'h1000, 64'h2000, 64'h40, 64'h100, 16'd1, 16'd1, 0, 0, 0, 0, 7, 1};
        tbl[1] = '{64'h8000, 64'h9000, 64'h48, 64'h24,  16'd2, 16'd3, 0, 0, 0, 0, 32, 6};
        tbl[2] = '{64'h8000, 64'h9000, 64'h48, 64'h24,  16'd2, 16'd3, 3, 4, 2, 0, -1, 6};
        tbl[3] = '{64'h4000, 64'h6000, 64'h40, 64'h20,  16'd3, 16'd0, 0, 0, 0, 0, 2, 0};
        tbl[4] = '{64'h4000, 64'h6000, 64'h40, 64'h20,  16'd0, 16'd2, 0, 0, 0, 0, 2, 0};

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i]);
            if (i == 0) chk("single_data", obs_wr_q[0][95:0], 96'h006F_006D_006B_0069_0067_0065);
            if (i == 1) chk("last_wr_addr", obs_wr_q[5][W-1:96], 64'h903C);
        end

        // negative values: one -1 per window, rotating through its four positions
        for (int i = 0; i < 12; i++) begin
            t[16*i +: 16] = 16'hFFFB;
            b[16*i +: 16] = 16'hFFFB;
        end
        for (int j = 0; j < 6; j++) begin
            case (j % 4)
                0: t[32*j +: 16]    = 16'hFFFF;
                1: t[32*j+16 +: 16] = 16'hFFFF;
                2: b[32*j +: 16]    = 16'hFFFF;
                default: b[32*j+16 +: 16] = 16'hFFFF;
            endcase
        end
        mem_a[64'h3000] = t;
        mem_a[64'h3040] = b;
        v = '{64'h3000, 64'h5000, 64'h40, 64'h40, 16'd1, 16'd1, 0, 0, 0, 0, 7, 1};
        run_job(v);
        chk("negative_max", obs_wr_q[0][95:0], {96{1'b1}});

        // start pulse mid-job is ignored
        v = tbl[1];
        v.mid = 8;
        run_job(v);

        // reset while waiting for the bottom read; the late rvalid must be ignored
        gnt_dly = 0; rv_dly = 6; wr_dly = 0;
        @(negedge clock);
        src_base = 64'hA000; dst_base = 64'hB000; src_stride = 64'h40; dst_stride = 64'h40;
        out_rows = 16'd1; chunks = 16'd2; start = 1'b1;
        n0 = n_rd_gnt;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 60 && n_rd_gnt < n0 + 2; k++) @(negedge clock);
        chk("reach_wait_bot", n_rd_gnt - n0, 2);
        @(negedge clock);
        reset = 1'b1;
        n0 = n_done;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rd_req", mem_if.rd_req, 0);
        chk("rst_mid_wr_req", mem_if.wr_req, 0);
        repeat (10) @(negedge clock);
        chk("late_rvalid_ignored", mem_if.pool_rdata, 0);
        chk("no_done_after_rst", n_done - n0, 0);
        chk("idle_rd_req", mem_if.rd_req, 0);
        run_job(tbl[0]);

        // randomized jobs
        for (int i = 0; i < 8; i++) begin
            v.src = {$urandom, $urandom};
            v.dst = {$urandom, $urandom};
            v.ss  = {$urandom, $urandom};
            v.ds  = {$urandom, $urandom};
            v.rows   = 16'($urandom_range(1, 3));
            v.chunks = 16'($urandom_range(1, 3));
            v.gd = $urandom_range(0, 3);
            v.rv = $urandom_range(0, 3);
            v.wd = $urandom_range(0, 3);
            v.mid = (i % 2 == 0) ? 5 : 0;
            v.exp_wr  = int'(v.rows) * int'(v.chunks);
            v.exp_lat = (v.gd == 0 && v.rv == 0 && v.wd == 0) ? 2 + 5 * v.exp_wr : -1;
            run_job(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/maxpool_seq_ctrl.md
# maxpool_seq_ctrl

Sequencer for the 2x2, stride-2 int16 max-pool datapath that reduces 24 halfwords (12 from a top row, 12 from the row below) to 6 results. The block walks a feature map stored in memory, performs two 192-bit reads (top and bottom row chunk) per output chunk, and presents them concatenated to the pooling datapath. It then writes the 96-bit pooled result back through a request/grant memory port. It sits between the accelerator's command registers and its shared memory port.

## Interface
- ADDR_W, 64, byte address width
- DIM_W, 16, width of row/chunk count fields
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle pulse; launches a job when idle
- src_base  in  ADDR_W  byte address of input row 0, chunk 0
- dst_base  in  ADDR_W  byte address of output row 0, chunk 0
- src_stride  in  ADDR_W  bytes between consecutive input rows
- dst_stride  in  ADDR_W  bytes between consecutive output rows
- out_rows  in  DIM_W  number of output rows (input row pairs)
- chunks  in  DIM_W  12-element input chunks per row (6 outputs each)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job completion
- rd_req  out  1  read request, held until granted
- rd_addr  out  ADDR_W  read byte address
- rd_gnt  in  1  read request accepted this cycle
- rd_rvalid  in  1  read data valid
- rd_rdata  in  192  12 x int16, element 0 in bits [15:0]
- pool_rdata  out  384  to datapath: {bottom chunk, top chunk}
- pool_wdata  in  96  from datapath: 6 pooled int16
- wr_req  out  1  write request, held until granted
- wr_addr  out  ADDR_W  write byte address
- wr_data  out  96  write data
- wr_gnt  in  1  write accepted this cycle

## Operation
- Configuration inputs are sampled into internal registers on accepted start and ignored afterward until the job ends.
- States: IDLE, RD_TOP, WAIT_TOP, RD_BOT, WAIT_BOT, WR, FIN.
- IDLE: start=1 latches config and clears r=0, c=0.
  - If out_rows==0 or chunks==0 -> FIN.
  - Otherwise -> RD_TOP.
- RD_TOP: rd_req=1, rd_addr = src_base + 2*r*src_stride + 24*c. On rd_gnt -> WAIT_TOP.
- WAIT_TOP: on rd_rvalid, latch rd_rdata into pool_rdata[191:0] -> RD_BOT.
- RD_BOT: rd_req=1, rd_addr = top address + src_stride. On rd_gnt -> WAIT_BOT.
- WAIT_BOT: on rd_rvalid, latch rd_rdata into pool_rdata[383:192] -> WR.
- WR: wr_req=1, wr_addr = dst_base + r*dst_stride + 12*c, wr_data = pool_wdata. On wr_gnt:
  - If c<chunks-1: c++ -> RD_TOP.
  - Else if r<out_rows-1: c=0, r++ -> RD_TOP.
  - Else -> FIN.
- FIN: done=1 for one cycle -> IDLE.
- Address arithmetic is unsigned modulo 2^ADDR_W; wrap is not flagged.
- Only one read is outstanding at a time. rd_rvalid outside WAIT_TOP/WAIT_BOT is ignored.
- start while busy is ignored; it is not queued.
- rd_addr/wr_addr/wr_data are held stable while the corresponding req is high and ungranted.

## Timing
- Reset values: busy=0, done=0, rd_req=0, wr_req=0, rd_addr=0, wr_addr=0, pool_rdata=0, state IDLE, r=c=0.
- Reset has priority over every event, including mid-job: outstanding req drops the next cycle, and late rd_rvalid/wr_gnt are ignored.
- busy rises the cycle after accepted start and falls in the cycle after FIN; it is high during FIN.
- rd_rvalid is legal no earlier than the cycle after rd_gnt.
- With immediate grants and 1-cycle read latency, each output chunk takes 5 cycles.
  - Job latency from start to done = 1 + 5*out_rows*chunks + 1 cycles.
  - Zero-size job: done 2 cycles after start.
- wr_data combinationally follows pool_wdata, which depends only on registered pool_rdata, so it is stable throughout WR.

## Test plan
- Single chunk: out_rows=1, chunks=1, src_base=0x1000, src_stride=0x40, top row elements 0..11, bottom row elements 100..111 -> reads at 0x1000 then 0x1040, one write to dst_base with elements {101,103,105,107,109,111}, done 7 cycles after start.
- Negative values: all inputs -5 except one -1 per 2x2 window -> every output is -1 (signed compare through datapath).
- Multi-row/chunk walk: out_rows=2, chunks=3, src_stride=0x48, dst_stride=0x24 -> 12 reads and 6 writes, in row-major order with correct addresses; last write at dst_base+0x24+24.
- Backpressure: rd_gnt delayed 3 cycles, rd_rvalid delayed 4 cycles, wr_gnt delayed 2 cycles -> rd_addr/wr_addr/wr_data are stable while stalled, results are identical, and done fires once.
- Zero size / start while busy: chunks=0 -> no rd_req, done 2 cycles after start. A start pulse mid-job is ignored, with exactly one done.
- Reset mid-job: assert reset in WAIT_BOT -> next cycle busy=0 and rd_req=wr_req=0. A late rd_rvalid is ignored, and a new job then runs correctly.
